// File: rtl/prefetch_queue.sv
// prefetch_queue
//   Instruction byte queue between the bus interface unit and pre_decode.
//   Fetches 16-bit code words into a circular byte buffer of DEPTH entries and
//   presents the three head bytes, the valid byte count and the head address.
//   Branches flush the queue and restart fetching at a new address.
//
// Parameters
//   DEPTH  queue capacity in bytes (4..16)
//   AW     fetch address width
//
// Ports
//   clk          core clock
//   reset_n      asynchronous active-low reset
//   ce           clock enable; nothing updates (acks included) while low
//   flush        discard queue contents, restart fetching at flush_addr
//   flush_addr   new fetch address, sampled with flush
//   consume_len  bytes popped from the head this cycle (0..3)
//   fetch_req    bus request level, held until fetch_ack
//   fetch_addr   fetch address, stable while fetch_req is high
//   fetch_ack    bus cycle complete, fetch_data valid
//   fetch_data   fetched word, low byte at the even address
//   q_len        valid bytes in the queue
//   q0, q1, q2   head bytes; positions at or beyond q_len read 8'h00
//   head_addr    address of q0
//
// Configuration
//   PREFETCH_BYPASS_EN  when defined, bytes arriving on an ack become visible
//                       on q_len/q0..q2 in the same cycle while q_len < 3.
//                       Undefined (default): outputs are purely registered.

module prefetch_queue_chk (
  input logic       clk,
  input logic       reset_n,
  input logic       ce,
  input logic       flush,
  input logic [2:0] consume_len,
  input logic [3:0] q_len
);
  // The datapath clamps an over-long consume; flag it so the caller gets fixed.
  a_consume_in_range: assert property (
    @(posedge clk) disable iff (!reset_n)
      (ce && !flush) |-> ({1'b0, consume_len} <= q_len)
  );
endmodule

module prefetch_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 20
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          flush,
  input  logic [AW-1:0] flush_addr,
  input  logic [2:0]    consume_len,
  output logic          fetch_req,
  output logic [AW-1:0] fetch_addr,
  input  logic          fetch_ack,
  input  logic [15:0]   fetch_data,
  output logic [3:0]    q_len,
  output logic [7:0]    q0,
  output logic [7:0]    q1,
  output logic [7:0]    q2,
  output logic [AW-1:0] head_addr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = 5;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] ONE_A   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] TWO_A   = {{(AW-2){1'b0}}, 2'b10};

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DISCARD = 2'd2} state_t;

  // Modulo-DEPTH pointer advance; works for non-power-of-2 DEPTH.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr,
                                            input logic [CW-1:0] inc);
    logic [CW:0] sum;
    logic [CW:0] wrapped;
    sum     = {{(CW+1-PW){1'b0}}, ptr} + {1'b0, inc};
    wrapped = sum - {1'b0, DEPTH_C};
    if (sum >= {1'b0, DEPTH_C}) return wrapped[PW-1:0];
    else                        return sum[PW-1:0];
  endfunction

  state_t        state_r;
  logic          fetch_req_r;
  logic [AW-1:0] fetch_addr_r;
  logic [AW-1:0] saved_addr_r;
  logic [7:0]    mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [3:0]    q_len_r;
  logic [7:0]    head_r [3];
  logic [AW-1:0] head_addr_r;

  logic          ack_s;
  logic [1:0]    push_n_s;
  logic [7:0]    push_b0_s;
  logic [7:0]    push_b1_s;
  logic [CW-1:0] avail_s;
  logic [CW-1:0] cons_s;
  logic [CW-1:0] count_next_s;
  logic [CW-1:0] space_next_s;
  logic [PW-1:0] rd_next_s;
  logic [PW-1:0] wr_next_s;
  logic [PW-1:0] wr_plus1_s;
  logic [PW-1:0] pos_s [3];
  logic [7:0]    peek_s [3];

  assign ack_s = ce & fetch_ack;

  // Bytes delivered by this cycle's ack; an odd address keeps only the high byte.
  always_comb begin
    push_b0_s = 8'h00;
    push_b1_s = 8'h00;
    if ((state_r == FETCH) && ack_s && !flush) begin
      if (fetch_addr_r[0]) begin
        push_n_s  = 2'd1;
        push_b0_s = fetch_data[15:8];
      end else begin
        push_n_s  = 2'd2;
        push_b0_s = fetch_data[7:0];
        push_b1_s = fetch_data[15:8];
      end
    end else begin
      push_n_s = 2'd0;
    end
  end

`ifdef PREFETCH_BYPASS_EN
  logic       bypass_s;
  logic [7:0] byp_s [3];

  assign bypass_s = (push_n_s != 2'd0) && (count_r < 5'd3);
  assign avail_s  = bypass_s ? (count_r + {3'b000, push_n_s}) : count_r;

  // Same-cycle view: registered head bytes followed by the incoming bytes.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      if (CW'(k) < count_r)                                  byp_s[k] = head_r[k];
      else if (CW'(k) == count_r)                            byp_s[k] = push_b0_s;
      else if ((CW'(k) == count_r + 5'd1) && (push_n_s == 2'd2)) byp_s[k] = push_b1_s;
      else                                                   byp_s[k] = 8'h00;
    end
  end

  assign q_len = bypass_s ? avail_s[3:0] : q_len_r;
  assign q0    = bypass_s ? byp_s[0] : head_r[0];
  assign q1    = bypass_s ? byp_s[1] : head_r[1];
  assign q2    = bypass_s ? byp_s[2] : head_r[2];
`else
  assign avail_s = count_r;
  assign q_len   = q_len_r;
  assign q0      = head_r[0];
  assign q1      = head_r[1];
  assign q2      = head_r[2];
`endif

  assign cons_s       = ({2'b00, consume_len} > avail_s) ? avail_s : {2'b00, consume_len};
  assign count_next_s = count_r + {3'b000, push_n_s} - cons_s;
  assign space_next_s = DEPTH_C - count_next_s;
  assign rd_next_s    = ptr_add(rd_ptr_r, cons_s);
  assign wr_next_s    = ptr_add(wr_ptr_r, {3'b000, push_n_s});
  assign wr_plus1_s   = ptr_add(wr_ptr_r, 5'd1);

  // Next head bytes; freshly pushed slots are taken from the ack data, not memory.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      pos_s[k] = ptr_add(rd_next_s, CW'(k));
      if (CW'(k) >= count_next_s)                                 peek_s[k] = 8'h00;
      else if ((push_n_s != 2'd0) && (pos_s[k] == wr_ptr_r))      peek_s[k] = push_b0_s;
      else if ((push_n_s == 2'd2) && (pos_s[k] == wr_plus1_s))    peek_s[k] = push_b1_s;
      else                                                        peek_s[k] = mem_r[pos_s[k]];
    end
  end

  // Byte storage, pointers and the registered head view.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 8'h00;
      for (int k = 0; k < 3; k++) head_r[k] <= 8'h00;
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      q_len_r     <= 4'd0;
      head_addr_r <= {AW{1'b0}};
    end else if (ce) begin
      if (flush) begin
        for (int k = 0; k < 3; k++) head_r[k] <= 8'h00;
        rd_ptr_r    <= wr_ptr_r;
        count_r     <= {CW{1'b0}};
        q_len_r     <= 4'd0;
        head_addr_r <= flush_addr;
      end else begin
        if (push_n_s != 2'd0) mem_r[wr_ptr_r]   <= push_b0_s;
        if (push_n_s == 2'd2) mem_r[wr_plus1_s] <= push_b1_s;
        for (int k = 0; k < 3; k++) head_r[k] <= peek_s[k];
        rd_ptr_r    <= rd_next_s;
        wr_ptr_r    <= wr_next_s;
        count_r     <= count_next_s;
        // With DEPTH=16 a full queue does not fit the 4-bit count.
        q_len_r     <= count_next_s[3:0];
        head_addr_r <= head_addr_r + {{(AW-CW){1'b0}}, cons_s};
      end
    end
  end

  // Fetch sequencer: request level, fetch address and pending flush target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      fetch_req_r  <= 1'b0;
      fetch_addr_r <= {AW{1'b0}};
      saved_addr_r <= {AW{1'b0}};
    end else if (ce) begin
      case (state_r)
        IDLE: begin
          if (flush) begin
            state_r      <= FETCH;
            fetch_req_r  <= 1'b1;
            fetch_addr_r <= flush_addr;
          end else if (space_next_s >= 5'd2) begin
            state_r     <= FETCH;
            fetch_req_r <= 1'b1;
          end
        end
        FETCH: begin
          if (flush && ack_s) begin
            fetch_addr_r <= flush_addr;
          end else if (flush) begin
            // Bus cycle still in flight: let it finish, then drop its data.
            state_r      <= DISCARD;
            saved_addr_r <= flush_addr;
          end else if (ack_s) begin
            fetch_addr_r <= fetch_addr_r + (fetch_addr_r[0] ? ONE_A : TWO_A);
            if (space_next_s >= 5'd2) begin
              state_r     <= FETCH;
              fetch_req_r <= 1'b1;
            end else begin
              state_r     <= IDLE;
              fetch_req_r <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (flush && ack_s) begin
            state_r      <= FETCH;
            fetch_addr_r <= flush_addr;
          end else if (flush) begin
            saved_addr_r <= flush_addr;
          end else if (ack_s) begin
            state_r      <= FETCH;
            fetch_addr_r <= saved_addr_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          fetch_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_req  = fetch_req_r;
  assign fetch_addr = fetch_addr_r;
  assign head_addr  = head_addr_r;

  prefetch_queue_chk u_chk (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .flush       (flush),
    .consume_len (consume_len),
    .q_len       (q_len)
  );
endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;
  logic        clk;
  logic        reset_n;
  logic        ce;
  logic        flush;
  logic [19:0] flush_addr;
  logic [2:0]  consume_len;
  logic        fetch_req;
  logic [19:0] fetch_addr;
  logic        fetch_ack;
  logic [15:0] fetch_data;
  logic [3:0]  q_len;
  logic [7:0]  q0, q1, q2;
  logic [19:0] head_addr;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  logic [19:0] exp_head;

  typedef struct {
    logic        fl;
    logic [19:0] fa;
    logic        ack;
    logic [15:0] data;
    logic [2:0]  cons;
    int          push_n;
    logic        exp_req;
    logic [19:0] exp_fa;
  } vec_t;

  vec_t vecs[21];

  prefetch_queue #(.DEPTH(8), .AW(20)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .consume_len (consume_len),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ack   (fetch_ack),
    .fetch_data  (fetch_data),
    .q_len       (q_len),
    .q0          (q0),
    .q1          (q1),
    .q2          (q2),
    .head_addr   (head_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    if (k < exp_q.size()) return exp_q[k];
    else return 8'h00;
  endfunction

  task automatic check_queue(input string tag);
    chk({tag, " q_len"}, {28'd0, q_len}, exp_q.size());
    chk({tag, " q0"}, {24'd0, q0}, {24'd0, exp_byte(0)});
    chk({tag, " q1"}, {24'd0, q1}, {24'd0, exp_byte(1)});
    chk({tag, " q2"}, {24'd0, q2}, {24'd0, exp_byte(2)});
    chk({tag, " head_addr"}, {12'd0, head_addr}, {12'd0, exp_head});
  endtask

  task automatic check_fetch(input string tag, input logic req, input logic [19:0] fa);
    chk({tag, " fetch_req"}, {31'd0, fetch_req}, {31'd0, req});
    chk({tag, " fetch_addr"}, {12'd0, fetch_addr}, {12'd0, fa});
  endtask

  // Drive one cycle; the expected queue contents are updated as stimulus goes out.
  task automatic cycle(input logic ce_v, input logic fl, input logic [19:0] fa,
                       input logic ack, input logic [15:0] data,
                       input logic [2:0] cons, input int push_n);
    ce          = ce_v;
    flush       = fl;
    flush_addr  = fa;
    fetch_ack   = ack;
    fetch_data  = data;
    consume_len = cons;
    if (ce_v) begin
      if (fl) begin
        exp_q.delete();
        exp_head = fa;
      end else begin
        for (int i = 0; i < int'(cons); i++) void'(exp_q.pop_front());
        exp_head = exp_head + {17'd0, cons};
        if (push_n == 1) begin
          exp_q.push_back(data[15:8]);
        end else if (push_n == 2) begin
          exp_q.push_back(data[7:0]);
          exp_q.push_back(data[15:8]);
        end
      end
    end
    @(posedge clk);
    #1;
    ce          = 1'b1;
    flush       = 1'b0;
    fetch_ack   = 1'b0;
    consume_len = 3'd0;
  endtask

  initial begin
    //            fl    fa          ack   data      cons  push req   exp fetch_addr
    vecs[0]  = '{1'b1, 20'h00100, 1'b0, 16'h0000, 3'd0, 0, 1'b1, 20'h00100};
    vecs[1]  = '{1'b0, 20'h00000, 1'b1, 16'h3412, 3'd0, 2, 1'b1, 20'h00102};
    vecs[2]  = '{1'b0, 20'h00000, 1'b1, 16'h7856, 3'd0, 2, 1'b1, 20'h00104};
    vecs[3]  = '{1'b1, 20'h00201, 1'b1, 16'h9999, 3'd0, 0, 1'b1, 20'h00201};
    vecs[4]  = '{1'b0, 20'h00000, 1'b1, 16'hAABB, 3'd0, 1, 1'b1, 20'h00202};
    vecs[5]  = '{1'b0, 20'h00000, 1'b0, 16'h0000, 3'd1, 0, 1'b1, 20'h00202};
    vecs[6]  = '{1'b0, 20'h00000, 1'b1, 16'h2211, 3'd0, 2, 1'b1, 20'h00204};
    vecs[7]  = '{1'b0, 20'h00000, 1'b1, 16'h4433, 3'd0, 2, 1'b1, 20'h00206};
    vecs[8]  = '{1'b0, 20'h00000, 1'b1, 16'h6655, 3'd0, 2, 1'b1, 20'h00208};
    vecs[9]  = '{1'b0, 20'h00000, 1'b1, 16'h8877, 3'd0, 2, 1'b0, 20'h0020A};
    vecs[10] = '{1'b0, 20'h00000, 1'b0, 16'h0000, 3'd0, 0, 1'b0, 20'h0020A};
    vecs[11] = '{1'b0, 20'h00000, 1'b0, 16'h0000, 3'd3, 0, 1'b1, 20'h0020A};
    vecs[12] = '{1'b0, 20'h00000, 1'b1, 16'hAA99, 3'd0, 2, 1'b0, 20'h0020C};
    vecs[13] = '{1'b0, 20'h00000, 1'b0, 16'h0000, 3'd3, 0, 1'b1, 20'h0020C};
    vecs[14] = '{1'b1, 20'h00400, 1'b0, 16'h0000, 3'd0, 0, 1'b1, 20'h0020C};
    vecs[15] = '{1'b0, 20'h00000, 1'b0, 16'h0000, 3'd0, 0, 1'b1, 20'h0020C};
    vecs[16] = '{1'b0, 20'h00000, 1'b1, 16'hDEAD, 3'd0, 0, 1'b1, 20'h00400};
    vecs[17] = '{1'b1, 20'h00600, 1'b0, 16'h0000, 3'd0, 0, 1'b1, 20'h00400};
    vecs[18] = '{1'b1, 20'h00700, 1'b0, 16'h0000, 3'd0, 0, 1'b1, 20'h00400};
    vecs[19] = '{1'b0, 20'h00000, 1'b1, 16'h1234, 3'd0, 0, 1'b1, 20'h00700};
    vecs[20] = '{1'b0, 20'h00000, 1'b1, 16'h0201, 3'd0, 2, 1'b1, 20'h00702};

    reset_n     = 1'b0;
    ce          = 1'b1;
    flush       = 1'b0;
    flush_addr  = 20'h00000;
    consume_len = 3'd0;
    fetch_ack   = 1'b0;
    fetch_data  = 16'h0000;
    exp_head    = 20'h00000;

    repeat (3) @(posedge clk);
    #1;
    check_queue("reset");
    check_fetch("reset", 1'b0, 20'h00000);

    // Out of reset the empty queue starts fetching at address 0.
    reset_n = 1'b1;
    cycle(1'b1, 1'b0, 20'h0, 1'b0, 16'h0000, 3'd0, 0);
    check_fetch("autostart", 1'b1, 20'h00000);
    cycle(1'b1, 1'b0, 20'h0, 1'b1, 16'h2211, 3'd0, 2);
    check_queue("prefill");
    check_fetch("prefill", 1'b1, 20'h00002);

    // Asynchronous reset in the middle of a fetch clears everything at once.
    reset_n = 1'b0;
    exp_q.delete();
    exp_head = 20'h00000;
    #1;
    check_queue("async_rst");
    check_fetch("async_rst", 1'b0, 20'h00000);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      cycle(1'b1, vecs[i].fl, vecs[i].fa, vecs[i].ack, vecs[i].data,
            vecs[i].cons, vecs[i].push_n);
      check_queue($sformatf("vec%0d", i));
      check_fetch($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_fa);
    end

    // Clock enable low: ack and consume are both ignored.
    cycle(1'b0, 1'b0, 20'h0, 1'b1, 16'h0403, 3'd2, 2);
    check_queue("ce_off");
    check_fetch("ce_off", 1'b1, 20'h00702);
    // Same inputs with ce high: consume 2 and push 2 in one cycle.
    cycle(1'b1, 1'b0, 20'h0, 1'b1, 16'h0403, 3'd2, 2);
    check_queue("ce_on");
    check_fetch("ce_on", 1'b1, 20'h00704);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
